cpu_storage_subsystem: RTL and testbench

- Combined storage block for the 12-bit-instruction / 4-bit-data teaching CPU.
- Contains three independent arrays, all on one clock and one reset:
  - an 8x12 instruction memory, loaded sequentially;
  - a 16x4 data memory with a registered read;
  - an 8x4 register file with two read ports and one write port.
- The CPU controller drives all three port groups directly. The arrays have no interaction with each other.

---
 rtl/cpu_storage_subsystem.sv | 127 ++++++++++++
 tb/tb_cpu_storage_subsystem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_storage_subsystem.sv
// Storage for the 12-bit-instruction / 4-bit-data teaching CPU: an append-loaded instruction
// memory, a data memory with registered read, and a 2R1W register file. Optional macro: RF_WRITE_BYPASS_EN.
module cpu_storage_subsystem #(
    parameter int INST_W   = 12,
    parameter int IM_DEPTH = 8,
    parameter int DATA_W   = 4,
    parameter int DM_DEPTH = 16,
    parameter int RF_DEPTH = 8,
    localparam int IM_AW   = $clog2(IM_DEPTH),
    localparam int DM_AW   = $clog2(DM_DEPTH),
    localparam int RF_AW   = $clog2(RF_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IM_AW-1:0]  im_index,
    input  logic [INST_W-1:0] im_new_instruction,
    input  logic              im_loading,
    output logic [INST_W-1:0] im_out,
    output logic [IM_AW-1:0]  im_wr_ptr,
    input  logic [DM_AW-1:0]  dm_address,
    input  logic [DATA_W-1:0] dm_write_data,
    input  logic              dm_write_enable,
    input  logic              dm_read_enable,
    output logic [DATA_W-1:0] dm_read_data,
    input  logic [RF_AW-1:0]  rf_read_address1,
    input  logic [RF_AW-1:0]  rf_read_address2,
    input  logic [RF_AW-1:0]  rf_write_address,
    input  logic [DATA_W-1:0] rf_write_data,
    input  logic              rf_write_enable,
    output logic [DATA_W-1:0] rf_read_data1,
    output logic [DATA_W-1:0] rf_read_data2
);

    logic [INST_W-1:0] imem_q [IM_DEPTH];
    logic [INST_W-1:0] imem_d [IM_DEPTH];
    logic [IM_AW-1:0]  im_wr_ptr_q;
    logic [IM_AW-1:0]  im_wr_ptr_d;

    logic [DATA_W-1:0] dmem_q [DM_DEPTH];
    logic [DATA_W-1:0] dmem_d [DM_DEPTH];
    logic [DATA_W-1:0] dm_read_data_q;
    logic [DATA_W-1:0] dm_read_data_d;

    logic [DATA_W-1:0] regs_q [RF_DEPTH];
    logic [DATA_W-1:0] regs_d [RF_DEPTH];

    // Instruction memory next state: append at the write pointer, pointer wraps naturally.
    always_comb begin
        imem_d      = imem_q;
        im_wr_ptr_d = im_wr_ptr_q;
        if (im_loading) begin
            imem_d[im_wr_ptr_q] = im_new_instruction;
            im_wr_ptr_d         = im_wr_ptr_q + {{(IM_AW-1){1'b0}}, 1'b1};
        end else begin
            im_wr_ptr_d = im_wr_ptr_q;
        end
    end

    // Data memory next state: the read samples the current array, so a same-edge write returns old data.
    always_comb begin
        dmem_d         = dmem_q;
        dm_read_data_d = dm_read_data_q;
        if (dm_read_enable) begin
            dm_read_data_d = dmem_q[dm_address];
        end else begin
            dm_read_data_d = dm_read_data_q;
        end
        if (dm_write_enable) begin
            dmem_d[dm_address] = dm_write_data;
        end else begin
            dmem_d[dm_address] = dmem_q[dm_address];
        end
    end

    // Register file next state; register 0 is an ordinary writable register.
    always_comb begin
        regs_d = regs_q;
        if (rf_write_enable) begin
            regs_d[rf_write_address] = rf_write_data;
        end else begin
            regs_d[rf_write_address] = regs_q[rf_write_address];
        end
    end

    // All storage state; the asynchronous clear also discards any write pending on this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            imem_q         <= '{default: '0};
            im_wr_ptr_q    <= '0;
            dmem_q         <= '{default: '0};
            dm_read_data_q <= '0;
            regs_q         <= '{default: '0};
        end else begin
            imem_q         <= imem_d;
            im_wr_ptr_q    <= im_wr_ptr_d;
            dmem_q         <= dmem_d;
            dm_read_data_q <= dm_read_data_d;
            regs_q         <= regs_d;
        end
    end

    assign im_out       = imem_q[im_index];
    assign im_wr_ptr    = im_wr_ptr_q;
    assign dm_read_data = dm_read_data_q;

`ifdef RF_WRITE_BYPASS_EN
    // Write-through: a port addressing the register being written sees the incoming data now.
    always_comb begin
        rf_read_data1 = regs_q[rf_read_address1];
        rf_read_data2 = regs_q[rf_read_address2];
        if (rf_write_enable && (rf_write_address == rf_read_address1)) begin
            rf_read_data1 = rf_write_data;
        end else begin
            rf_read_data1 = regs_q[rf_read_address1];
        end
        if (rf_write_enable && (rf_write_address == rf_read_address2)) begin
            rf_read_data2 = rf_write_data;
        end else begin
            rf_read_data2 = regs_q[rf_read_address2];
        end
    end
`else
    assign rf_read_data1 = regs_q[rf_read_address1];
    assign rf_read_data2 = regs_q[rf_read_address2];
`endif

endmodule

// File: tb/tb_cpu_storage_subsystem.sv
// Self-checking bench for cpu_storage_subsystem: directed scenarios plus random traffic vs an array model.
module tb_cpu_storage_subsystem;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  im_index;
    logic [11:0] im_new_instruction;
    logic        im_loading;
    logic [11:0] im_out;
    logic [2:0]  im_wr_ptr;
    logic [3:0]  dm_address;
    logic [3:0]  dm_write_data;
    logic        dm_write_enable;
    logic        dm_read_enable;
    logic [3:0]  dm_read_data;
    logic [2:0]  rf_read_address1;
    logic [2:0]  rf_read_address2;
    logic [2:0]  rf_write_address;
    logic [3:0]  rf_write_data;
    logic        rf_write_enable;
    logic [3:0]  rf_read_data1;
    logic [3:0]  rf_read_data2;

    int total = 0;
    int bad   = 0;

    logic [11:0] m_im [8];
    int          m_ptr;
    logic [3:0]  m_dm [16];
    logic [3:0]  m_rd;
    logic [3:0]  m_rf [8];

    always #5 clk = ~clk;

    cpu_storage_subsystem dut (
        .clk                (clk),
        .reset              (reset),
        .im_index           (im_index),
        .im_new_instruction (im_new_instruction),
        .im_loading         (im_loading),
        .im_out             (im_out),
        .im_wr_ptr          (im_wr_ptr),
        .dm_address         (dm_address),
        .dm_write_data      (dm_write_data),
        .dm_write_enable    (dm_write_enable),
        .dm_read_enable     (dm_read_enable),
        .dm_read_data       (dm_read_data),
        .rf_read_address1   (rf_read_address1),
        .rf_read_address2   (rf_read_address2),
        .rf_write_address   (rf_write_address),
        .rf_write_data      (rf_write_data),
        .rf_write_enable    (rf_write_enable),
        .rf_read_data1      (rf_read_data1),
        .rf_read_data2      (rf_read_data2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_im[i] = 12'h000;
        for (int i = 0; i < 16; i++) m_dm[i] = 4'h0;
        for (int i = 0; i < 8; i++) m_rf[i] = 4'h0;
        m_ptr = 0;
        m_rd  = 4'h0;
    endtask

    task automatic idle();
        im_loading      = 1'b0;
        dm_write_enable = 1'b0;
        dm_read_enable  = 1'b0;
        rf_write_enable = 1'b0;
    endtask

    function automatic logic [3:0] exp_rf(input logic [2:0] a);
`ifdef RF_WRITE_BYPASS_EN
        if (rf_write_enable && rf_write_address == a) return rf_write_data;
`endif
        return m_rf[a];
    endfunction

    // One rising edge; the model absorbs the inputs that were stable at the edge.
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            if (im_loading) begin
                m_im[m_ptr] = im_new_instruction;
                m_ptr = (m_ptr + 1) % 8;
            end
            if (dm_read_enable) m_rd = m_dm[dm_address];
            if (dm_write_enable) m_dm[dm_address] = dm_write_data;
            if (rf_write_enable) m_rf[rf_write_address] = rf_write_data;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        #1;
        check_val({tag, ".im_out"}, {20'd0, im_out}, {20'd0, m_im[im_index]});
        check_val({tag, ".im_wr_ptr"}, {29'd0, im_wr_ptr}, m_ptr);
        check_val({tag, ".dm_read_data"}, {28'd0, dm_read_data}, {28'd0, m_rd});
        check_val({tag, ".rf_rd1"}, {28'd0, rf_read_data1}, {28'd0, exp_rf(rf_read_address1)});
        check_val({tag, ".rf_rd2"}, {28'd0, rf_read_data2}, {28'd0, exp_rf(rf_read_address2)});
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, ".im_out"}, {20'd0, im_out}, 32'd0);
        check_val({tag, ".im_wr_ptr"}, {29'd0, im_wr_ptr}, 32'd0);
        check_val({tag, ".dm_read_data"}, {28'd0, dm_read_data}, 32'd0);
        check_val({tag, ".rf_rd1"}, {28'd0, rf_read_data1}, 32'd0);
        check_val({tag, ".rf_rd2"}, {28'd0, rf_read_data2}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        model_clear();
        #2;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        im_index = 3'd0; im_new_instruction = 12'h000;
        dm_address = 4'h0; dm_write_data = 4'h0;
        rf_read_address1 = 3'd0; rf_read_address2 = 3'd0;
        rf_write_address = 3'd0; rf_write_data = 4'h0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_zero("reset");

        // Three sequential loads
        im_loading = 1'b1;
        im_new_instruction = 12'h611; tick();
        im_new_instruction = 12'h0A5; tick();
        im_new_instruction = 12'hFFF; tick();
        im_loading = 1'b0;
        for (int i = 0; i < 3; i++) begin
            im_index = 3'(i);
            check_all($sformatf("load3_%0d", i));
        end
        im_index = 3'd0; #1 check_val("load3.im0", {20'd0, im_out}, 32'h611);
        im_index = 3'd2; #1 check_val("load3.im2", {20'd0, im_out}, 32'hFFF);
        check_val("load3.ptr", {29'd0, im_wr_ptr}, 32'd3);

        // Nine appends from a cleared pointer wrap and overwrite entry 0
        pulse_reset();
        im_loading = 1'b1;
        for (int v = 1; v <= 9; v++) begin
            im_new_instruction = 12'(v);
            tick();
        end
        im_loading = 1'b0;
        check_val("wrap.ptr", {29'd0, im_wr_ptr}, 32'd1);
        im_index = 3'd0; #1 check_val("wrap.im0", {20'd0, im_out}, 32'd9);
        im_index = 3'd1; #1 check_val("wrap.im1", {20'd0, im_out}, 32'd2);
        im_index = 3'd7; #1 check_val("wrap.im7", {20'd0, im_out}, 32'd8);

        // Data memory write, then registered read, then same-edge read/write
        dm_address = 4'hF; dm_write_data = 4'hA; dm_write_enable = 1'b1; tick();
        dm_write_enable = 1'b0; dm_read_enable = 1'b1; tick();
        dm_read_enable = 1'b0;
        check_val("dm.read", {28'd0, dm_read_data}, 32'hA);
        dm_write_data = 4'h3; dm_write_enable = 1'b1; dm_read_enable = 1'b1; tick();
        idle();
        check_val("dm.rw_old", {28'd0, dm_read_data}, 32'hA);
        tick();
        check_val("dm.hold", {28'd0, dm_read_data}, 32'hA);
        dm_read_enable = 1'b1; tick(); dm_read_enable = 1'b0;
        check_val("dm.new", {28'd0, dm_read_data}, 32'h3);

        // Register file writes and same-cycle read of a register being written
        rf_write_enable = 1'b1;
        rf_write_address = 3'd3; rf_write_data = 4'h5; tick();
        rf_write_address = 3'd6; rf_write_data = 4'h9; tick();
        rf_write_enable = 1'b0;
        rf_read_address1 = 3'd3; rf_read_address2 = 3'd6;
        #1 check_val("rf.r3", {28'd0, rf_read_data1}, 32'h5);
        check_val("rf.r6", {28'd0, rf_read_data2}, 32'h9);
        rf_write_enable = 1'b1; rf_write_address = 3'd3; rf_write_data = 4'h7;
`ifdef RF_WRITE_BYPASS_EN
        #1 check_val("rf.same_cycle", {28'd0, rf_read_data1}, 32'h7);
`else
        #1 check_val("rf.same_cycle", {28'd0, rf_read_data1}, 32'h5);
`endif
        tick();
        rf_write_enable = 1'b0;
        #1 check_val("rf.after", {28'd0, rf_read_data1}, 32'h7);
        rf_read_address2 = 3'd3;
        #1 check_val("rf.dual_same", {28'd0, rf_read_data2}, 32'h7);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            im_index           = 3'($urandom_range(0, 7));
            im_new_instruction = 12'($urandom);
            im_loading         = ($urandom_range(0, 3) == 0);
            dm_address         = 4'($urandom_range(0, 15));
            dm_write_data      = 4'($urandom);
            dm_write_enable    = ($urandom_range(0, 1) == 1);
            dm_read_enable     = ($urandom_range(0, 1) == 1);
            rf_read_address1   = 3'($urandom_range(0, 7));
            rf_read_address2   = 3'($urandom_range(0, 7));
            rf_write_address   = 3'($urandom_range(0, 7));
            rf_write_data      = 4'($urandom);
            rf_write_enable    = ($urandom_range(0, 1) == 1);
            check_all($sformatf("rand%0d", n));
            tick();
        end

        // Asynchronous reset mid-stream with strobes active
        im_loading = 1'b1; dm_write_enable = 1'b1; dm_read_enable = 1'b1; rf_write_enable = 1'b1;
        reset = 1'b0;
        model_clear();
        #1 check_zero("async_rst");
        tick();
        tick();
        rf_write_enable = 1'b0;
        #1 check_zero("rst_held");
        idle();
        reset = 1'b1;
        for (int n = 0; n < 20; n++) begin
            im_index         = 3'($urandom_range(0, 7));
            rf_read_address1 = 3'($urandom_range(0, 7));
            rf_read_address2 = 3'($urandom_range(0, 7));
            dm_address       = 4'($urandom_range(0, 15));
            dm_read_enable   = 1'b1;
            check_all($sformatf("post_rst%0d", n));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
